// File: rtl/logic_dispatch.sv
// logic_dispatch: issue front end for the pipelined logic unit.
// Registers operands/op for the unit, carries destination tags through a
// shadow pipe aligned with the unit's latency, and stalls issue on RAW/WAW
// hazards using a per-register busy scoreboard.
module logic_dispatch #(
  parameter int LU_LAT = 3,
  parameter int NREG   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] lu_a,
  output logic [31:0] lu_b,
  output logic [2:0]  lu_op,
  input  logic [31:0] lu_result,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        idle
);

  // Decoded instruction fields
  logic [2:0] op;
  logic [4:0] rd, rs1, rs2;
  logic       unused_bits;

  assign op          = in_instr[31:29];
  assign rd          = in_instr[28:24];
  assign rs1         = in_instr[23:19];
  assign rs2         = in_instr[18:14];
  assign unused_bits = ^in_instr[13:0];

  // Shadow pipe: index 0 is loaded alongside lu_a/lu_b/lu_op, index LU_LAT
  // lines up with lu_result being valid.
  logic [LU_LAT:0]      vld_pipe;
  logic [LU_LAT:0][4:0] rd_pipe;

  logic [NREG-1:0] busy, busy_nxt;
  logic            xfer;
  logic            retire;

  assign retire = vld_pipe[LU_LAT];

  // Issue is allowed only when no source or destination is still in flight
  assign in_ready = !rst && !busy[rs1] && !busy[rs2] && !busy[rd];
  assign xfer     = in_valid && in_ready;

  assign idle = !(|vld_pipe) && !wb_valid && (busy == '0);

  // Scoreboard update: clear on write-back, set on issue (set wins), r0 never busy
  always_comb begin
    busy_nxt = busy;
    if (retire)
      busy_nxt[rd_pipe[LU_LAT]] = 1'b0;
    if (xfer && rd != 5'd0)
      busy_nxt[rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Operand registers, shadow pipe, write-back and scoreboard state
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_a     <= '0;
      lu_b     <= '0;
      lu_op    <= '0;
      vld_pipe <= '0;
      rd_pipe  <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      busy     <= '0;
    end else begin
      vld_pipe[0] <= xfer;
      if (xfer) begin
        lu_a       <= rs1_data;
        lu_b       <= rs2_data;
        lu_op      <= op;
        rd_pipe[0] <= rd;
      end
      for (int i = 1; i <= LU_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        rd_pipe[i]  <= rd_pipe[i-1];
      end
      wb_valid <= retire;
      if (retire) begin
        wb_rd   <= rd_pipe[LU_LAT];
        wb_data <= lu_result;
      end
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_logic_dispatch.sv
// tb_logic_dispatch: random + directed stimulus; expected write-backs are
// queued at issue and popped/compared by an independent monitor.
module tb_logic_dispatch;
  localparam int LU_LAT = 3;
  localparam int LAT    = LU_LAT + 1;  // issue edge to wb_valid cycle

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_instr = '0, rs1_data = '0, rs2_data = '0;
  logic [31:0] lu_a, lu_b, lu_result;
  logic [2:0]  lu_op;
  logic        wb_valid, idle;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int total = 0, bad = 0, cyc = 0;

  typedef struct { int rd; logic [31:0] data; int due; } exp_t;
  exp_t sb[$];

  logic_dispatch #(.LU_LAT(LU_LAT), .NREG(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .lu_a(lu_a), .lu_b(lu_b), .lu_op(lu_op), .lu_result(lu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .idle(idle));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] lu_f(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction

  // Logic unit model: three register stages after lu_a/lu_b/lu_op
  logic [31:0] p1 = '0, p2 = '0, p3 = '0;
  always @(posedge clk) begin
    p1 <= lu_f(lu_op, lu_a, lu_b);
    p2 <= p1;
    p3 <= p2;
  end
  assign lu_result = p3;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // A register is busy from its issue edge until its write-back cycle
  function automatic bit reg_busy(int r);
    if (r == 0) return 0;
    foreach (sb[i])
      if (sb[i].rd == r && sb[i].due - LAT <= cyc && cyc < sb[i].due) return 1;
    return 0;
  endfunction

  // Monitor: idle and write-back checks against the expected queue
  always @(negedge clk) begin
    if (!rst) begin
      bit idle_exp;
      exp_t e;
      idle_exp = 1;
      foreach (sb[i]) if (sb[i].due - LAT <= cyc) idle_exp = 0;
      chk("idle", idle, idle_exp);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("wb_valid", wb_valid, 1);
        if (wb_valid) begin
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_data", wb_data, e.data);
        end
      end else begin
        chk("wb_valid_idle", wb_valid, 0);
      end
    end
  end

  // Present one instruction for one cycle; reports whether it transferred
  task automatic offer(bit v, logic [2:0] op, int rd, int rs1, int rs2,
                       logic [31:0] d1, logic [31:0] d2, output bit took);
    bit rdy_exp;
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_instr = {op, 5'(rd), 5'(rs1), 5'(rs2), 14'($urandom)};
    rs1_data = d1;
    rs2_data = d2;
    #1;
    rdy_exp = !reg_busy(rs1) && !reg_busy(rs2) && !reg_busy(rd);
    chk("in_ready", in_ready, rdy_exp);
    took = v && in_ready;
    if (took) begin
      e.rd = rd; e.data = lu_f(op, d1, d2); e.due = cyc + 1 + LAT;
      sb.push_back(e);
    end
  endtask

  // Hold an instruction until it transfers, with a bounded wait
  task automatic issue(logic [2:0] op, int rd, int rs1, int rs2,
                       logic [31:0] d1, logic [31:0] d2);
    bit took = 0;
    for (int n = 0; n < 30 && !took; n++) offer(1, op, rd, rs1, rs2, d1, d2, took);
    if (!took) begin
      bad++; total++;
      $display("FAIL issue_timeout rd=%0d rs1=%0d rs2=%0d got no transfer expected one", rd, rs1, rs2);
    end
  endtask

  task automatic gap(int n);
    bit t;
    for (int i = 0; i < n; i++)
      offer(0, 3'($urandom), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom, $urandom, t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0;
    #1 chk("in_ready_rst", in_ready, 0);
    @(negedge clk);
    sb.delete();
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_idle", idle, 1);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    bit t;
    // Reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_idle", idle, 1);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_lu_a", lu_a, 0);
    chk("reset_lu_b", lu_b, 0);
    chk("reset_lu_op", lu_op, 0);
    chk("reset_wb_rd", wb_rd, 0);
    chk("reset_wb_data", wb_data, 0);
    rst = 0;
    #1 chk("reset_in_ready", in_ready, 1);

    // Single AND op
    issue(3'b000, 5, 1, 2, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    @(negedge clk);
    in_valid = 0;
    chk("lu_a", lu_a, 32'hF0F0_F0F0);
    chk("lu_b", lu_b, 32'h0FF0_0FF0);
    chk("lu_op", lu_op, 0);
    gap(8);

    // RAW on r7
    issue(3'd1, 7, 3, 4, 32'h1234_0000, 32'h0000_5678);
    issue(3'd2, 8, 7, 4, 32'hAAAA_5555, 32'hFFFF_0000);
    gap(8);

    // WAW on r9, then r0 back-to-back
    issue(3'd3, 9, 1, 2, $urandom, $urandom);
    issue(3'd4, 9, 3, 4, $urandom, $urandom);
    issue(3'd5, 0, 1, 2, $urandom, $urandom);
    issue(3'd6, 0, 3, 4, $urandom, $urandom);
    gap(8);

    // Streaming independent ops
    for (int i = 0; i < 8; i++) issue(3'(i), i + 1, 20 + i, 27 - i, $urandom, $urandom);
    gap(8);

    // Reset with ops in flight
    for (int i = 0; i < 3; i++) issue(3'(i), 10 + i, 1, 2, $urandom, $urandom);
    do_reset();
    gap(8);

    // Random traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++)
      offer($urandom_range(0, 9) < 7, 3'($urandom), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom, $urandom, t);
    gap(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
